// File: rtl/datapath_ext.sv
// LC-3 style datapath: gated bus, register file, ALU, address adder, CC/BEN
// and a two-state memory access controller with busy timeout.
module datapath_ext #(
   parameter int WIDTH       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Mem_Rdata,
   input  logic             Mem_Ready,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_BEN,
   input  logic             LD_REG,
   input  logic             LD_CC,
   input  logic             LD_PC,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateALU,
   input  logic             GateMARMUX,
   input  logic             ADDR1MUX,
   input  logic             SR2MUX,
   input  logic             MARMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       DRMUX,
   input  logic [1:0]       SR1MUX,
   input  logic [1:0]       ALUK,
   input  logic             MEM_Start,
   input  logic             MEM_Write,
   output logic [WIDTH-1:0] Mem_Addr,
   output logic [WIDTH-1:0] Mem_Wdata,
   output logic             Mem_CE,
   output logic             Mem_WE,
   output logic             R,
   output logic             Mem_Err,
   output logic             BEN,
   output logic             IR_5,
   output logic [3:0]       IR_15_12,
   output logic             Bus_Conflict
);

   typedef enum logic {IDLE, BUSY} mem_state_t;

   mem_state_t       state, state_nxt;
   logic [7:0]       cnt;
   logic             timeout;

   logic [WIDTH-1:0] mar, mdr, ir, pc;
   logic             n_flag, z_flag, p_flag;
   logic [WIDTH-1:0] regs [8];

   logic [2:0]       sr1_idx, dr_idx;
   logic [WIDTH-1:0] sr1_data, sr2_data;
   logic [WIDTH-1:0] alu_b, alu_out;
   logic [WIDTH-1:0] addr1, addr_sum, marmux_out, pc_nxt, bus;

   logic signed [WIDTH-1:0] imm5, off6, off9, off11, addr2;

   function automatic logic [2:0] count_gates(input logic [3:0] g);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 4; i++) c = c + 3'(g[i]);
      return c;
   endfunction

   // Operand selection and immediates (all offsets sign-extended)
   assign imm5  = WIDTH'($signed(ir[4:0]));
   assign off6  = WIDTH'($signed(ir[5:0]));
   assign off9  = WIDTH'($signed(ir[8:0]));
   assign off11 = WIDTH'($signed(ir[10:0]));

   always_comb begin
      sr1_idx = 3'd0;
      case (SR1MUX)
         2'b00:   sr1_idx = ir[11:9];
         2'b01:   sr1_idx = ir[8:6];
         2'b10:   sr1_idx = 3'd6;
         default: sr1_idx = 3'd0;
      endcase
      dr_idx = 3'd0;
      case (DRMUX)
         2'b00:   dr_idx = ir[11:9];
         2'b01:   dr_idx = 3'd7;
         2'b10:   dr_idx = 3'd6;
         default: dr_idx = 3'd0;
      endcase
   end

   assign sr1_data = regs[sr1_idx];
   assign sr2_data = regs[ir[2:0]];
   assign alu_b    = SR2MUX ? $unsigned(imm5) : sr2_data;

   always_comb begin
      alu_out = '0;
      case (ALUK)
         2'b00:   alu_out = sr1_data + alu_b;
         2'b01:   alu_out = sr1_data & alu_b;
         2'b10:   alu_out = ~sr1_data;
         default: alu_out = sr1_data;
      endcase
      addr2 = '0;
      case (ADDR2MUX)
         2'b00:   addr2 = '0;
         2'b01:   addr2 = off6;
         2'b10:   addr2 = off9;
         default: addr2 = off11;
      endcase
   end

   assign addr1      = ADDR1MUX ? sr1_data : pc;
   assign addr_sum   = addr1 + $unsigned(addr2);
   assign marmux_out = MARMUX ? addr_sum : {{(WIDTH-8){1'b0}}, ir[7:0]};

   always_comb begin
      pc_nxt = pc;
      case (PCMUX)
         2'b00:   pc_nxt = pc + WIDTH'(1);
         2'b01:   pc_nxt = bus;
         2'b10:   pc_nxt = addr_sum;
         default: pc_nxt = pc;
      endcase
   end

   // Bus: exactly one gate drives it, otherwise it reads as zero
   always_comb begin
      bus = '0;
      case ({GatePC, GateMDR, GateALU, GateMARMUX})
         4'b1000: bus = pc;
         4'b0100: bus = mdr;
         4'b0010: bus = alu_out;
         4'b0001: bus = marmux_out;
         default: bus = '0;
      endcase
   end

   assign Bus_Conflict = (count_gates({GatePC, GateMDR, GateALU, GateMARMUX}) > 3'd1);

   // Memory access controller
   assign timeout = (state == BUSY) && !Mem_Ready && (cnt == 8'(MEM_TIMEOUT - 1));
   assign Mem_CE  = (state == BUSY);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (MEM_Start) state_nxt = BUSY;
         BUSY:    if (Mem_Ready || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         Mem_Addr  <= '0;
         Mem_Wdata <= '0;
         Mem_WE    <= 1'b0;
         R         <= 1'b0;
         Mem_Err   <= 1'b0;
      end else begin
         state <= state_nxt;
         R     <= 1'b0;
         if (state == IDLE) begin
            if (MEM_Start) begin
               Mem_Addr  <= mar;
               Mem_Wdata <= mdr;
               Mem_WE    <= MEM_Write;
               cnt       <= 8'd0;
               Mem_Err   <= 1'b0;
            end
         end else if (Mem_Ready) begin
            R      <= 1'b1;
            Mem_WE <= 1'b0;
         end else if (timeout) begin
            R       <= 1'b1;
            Mem_WE  <= 1'b0;
            Mem_Err <= 1'b1;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // Architectural registers; MDR is owned by the memory side while busy
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mar    <= '0;
         mdr    <= '0;
         ir     <= '0;
         pc     <= '0;
         BEN    <= 1'b0;
         n_flag <= 1'b0;
         z_flag <= 1'b0;
         p_flag <= 1'b0;
      end else begin
         if (LD_MAR) mar <= bus;
         if (state == IDLE) begin
            if (LD_MDR) mdr <= bus;
         end else if (Mem_Ready && !Mem_WE) begin
            mdr <= Mem_Rdata;
         end
         if (LD_IR) ir <= bus;
         if (LD_PC) pc <= pc_nxt;
         if (LD_BEN) BEN <= (ir[11] & n_flag) | (ir[10] & z_flag) | (ir[9] & p_flag);
         if (LD_CC) begin
            n_flag <= bus[WIDTH-1];
            z_flag <= (bus == '0);
            p_flag <= ~bus[WIDTH-1] & (bus != '0);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (LD_REG) begin
         regs[dr_idx] <= bus;
      end
   end

   assign IR_5     = ir[5];
   assign IR_15_12 = ir[15:12];

endmodule

// File: tb/tb_datapath_ext.sv
// Directed bench for datapath_ext: vector table for bus/ALU/address paths,
// hand sequences for memory handshake, timeout, reset-abort and a 32-bit build.
module tb_datapath_ext;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] Mem_Rdata;
   logic        Mem_Ready;
   logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
   logic        GatePC, GateMDR, GateALU, GateMARMUX;
   logic        ADDR1MUX, SR2MUX, MARMUX;
   logic [1:0]  ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
   logic        MEM_Start, MEM_Write;
   logic [15:0] Mem_Addr, Mem_Wdata;
   logic        Mem_CE, Mem_WE, R, Mem_Err, BEN, IR_5, Bus_Conflict;
   logic [3:0]  IR_15_12;

   logic [31:0] rdata32, addr32, wdata32;
   logic        ce32, we32, r32, err32, ben32, ir5_32, conf32;
   logic [3:0]  ir1512_32;

   int total = 0;
   int bad   = 0;
   int ce_cnt;

   always #5 Clk = ~Clk;

   assign rdata32 = {16'h0000, Mem_Rdata};

   datapath_ext dut (
      .Clk(Clk), .Reset(Reset), .Mem_Rdata(Mem_Rdata), .Mem_Ready(Mem_Ready),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_PC(LD_PC),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .ADDR1MUX(ADDR1MUX), .SR2MUX(SR2MUX), .MARMUX(MARMUX), .ADDR2MUX(ADDR2MUX),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ALUK(ALUK),
      .MEM_Start(MEM_Start), .MEM_Write(MEM_Write),
      .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .Mem_CE(Mem_CE), .Mem_WE(Mem_WE),
      .R(R), .Mem_Err(Mem_Err), .BEN(BEN), .IR_5(IR_5), .IR_15_12(IR_15_12),
      .Bus_Conflict(Bus_Conflict)
   );

   datapath_ext #(.WIDTH(32)) dut32 (
      .Clk(Clk), .Reset(Reset), .Mem_Rdata(rdata32), .Mem_Ready(Mem_Ready),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_PC(LD_PC),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .ADDR1MUX(ADDR1MUX), .SR2MUX(SR2MUX), .MARMUX(MARMUX), .ADDR2MUX(ADDR2MUX),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ALUK(ALUK),
      .MEM_Start(MEM_Start), .MEM_Write(MEM_Write),
      .Mem_Addr(addr32), .Mem_Wdata(wdata32), .Mem_CE(ce32), .Mem_WE(we32),
      .R(r32), .Mem_Err(err32), .BEN(ben32), .IR_5(ir5_32), .IR_15_12(ir1512_32),
      .Bus_Conflict(conf32)
   );

   typedef struct {
      logic [15:0] ir;
      logic [1:0]  sr1mux;
      logic        sr2mux;
      logic [1:0]  aluk;
      logic        addr1mux;
      logic [1:0]  addr2mux;
      logic        marmux;
      logic [1:0]  src;      // 0 ALU, 1 MARMUX, 2 PC
      logic [15:0] exp_bus;
   } vec_t;

   vec_t vecs [15];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_ctl();
      LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_REG = 0; LD_CC = 0; LD_PC = 0;
      GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
      ADDR1MUX = 0; SR2MUX = 0; MARMUX = 0; ADDR2MUX = 0; PCMUX = 0; DRMUX = 0;
      SR1MUX = 0; ALUK = 0; MEM_Start = 0; MEM_Write = 0;
   endtask

   // Read with Ready on the first busy cycle; leaves the value in MDR
   task automatic load_mdr(input logic [15:0] val);
      MEM_Write = 0; MEM_Start = 1;
      tick();
      MEM_Start = 0; Mem_Ready = 1; Mem_Rdata = val;
      tick();
      Mem_Ready = 0;
      tick();
   endtask

   task automatic load_ir(input logic [15:0] val);
      load_mdr(val);
      GateMDR = 1; LD_IR = 1;
      tick();
      clear_ctl();
   endtask

   initial begin
      vecs[0]  = '{16'h1442, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 16'hFFFF};
      vecs[1]  = '{16'h1442, 2'b01, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'd0, 16'h0000};
      vecs[2]  = '{16'h1442, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'd0, 16'h8000};
      vecs[3]  = '{16'h1442, 2'b01, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0, 16'h7FFF};
      vecs[4]  = '{16'h1442, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 16'h8001};
      vecs[5]  = '{16'h147F, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 16'h7FFE};
      vecs[6]  = '{16'h147F, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 16'h7FFF};
      vecs[7]  = '{16'h147F, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 16'hFFFF};
      vecs[8]  = '{16'h147F, 2'b11, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0, 16'h0000};
      vecs[9]  = '{16'hF0FF, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd1, 16'h00FF};
      vecs[10] = '{16'h147F, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 2'd1, 16'h7FFE};
      vecs[11] = '{16'h147F, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 2'd1, 16'h30CF};
      vecs[12] = '{16'h147F, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11, 1'b1, 2'd1, 16'h2CCF};
      vecs[13] = '{16'h147F, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'd1, 16'h3050};
      vecs[14] = '{16'h1442, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd2, 16'h3050};

      clear_ctl();
      Mem_Ready = 0; Mem_Rdata = 16'h0000;
      Reset = 1;
      tick(); tick();
      Reset = 0;
      check("rst ce", Mem_CE, 0);
      check("rst we", Mem_WE, 0);
      check("rst r", R, 0);
      check("rst err", Mem_Err, 0);
      check("rst addr", Mem_Addr, 0);
      check("rst ben", BEN, 0);
      check("rst pc", dut.pc, 0);

      // Read: Ready after three busy cycles
      load_mdr(16'h3000);
      GateMDR = 1; LD_MAR = 1;
      tick();
      clear_ctl();
      check("mar load", dut.mar, 16'h3000);
      MEM_Start = 1;
      tick();
      MEM_Start = 0;
      check("rd addr", Mem_Addr, 16'h3000);
      check("rd we", Mem_WE, 0);
      ce_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         if (Mem_CE) ce_cnt++;
         if (R) ce_cnt += 100;
         if (k == 2) begin Mem_Ready = 1; Mem_Rdata = 16'h1234; end
         tick();
      end
      Mem_Ready = 0;
      check("rd ce cycles", ce_cnt, 3);
      check("rd ce done", Mem_CE, 0);
      check("rd r pulse", R, 1);
      check("rd mdr", dut.mdr, 16'h1234);
      check("rd err", Mem_Err, 0);
      tick();
      check("rd r single", R, 0);

      // Write that never completes
      load_mdr(16'hBEEF);
      MEM_Write = 1; MEM_Start = 1;
      tick();
      MEM_Start = 0; MEM_Write = 0;
      check("wr we", Mem_WE, 1);
      check("wr wdata", Mem_Wdata, 16'hBEEF);
      ce_cnt = 0;
      while (Mem_CE && ce_cnt < 40) begin
         ce_cnt++;
         tick();
      end
      check("to busy cycles", ce_cnt, 15);
      check("to r pulse", R, 1);
      check("to err", Mem_Err, 1);
      check("to mdr kept", dut.mdr, 16'hBEEF);
      check("to we low", Mem_WE, 0);
      tick();
      check("to r single", R, 0);
      check("to err sticky", Mem_Err, 1);

      load_mdr(16'h3050);
      check("err cleared", Mem_Err, 0);
      GateMDR = 1; PCMUX = 2'b01; LD_PC = 1;
      tick();
      clear_ctl();
      check("pc bus load", dut.pc, 16'h3050);

      // R1 = 0x7FFF, then ADD R2, R1, #1 with CC
      load_ir(16'h0200);
      load_mdr(16'h7FFF);
      GateMDR = 1; LD_REG = 1; DRMUX = 2'b00;
      tick();
      clear_ctl();
      check("r1 load", dut.regs[1], 16'h7FFF);
      load_ir(16'h1461);
      check("ir 15_12", IR_15_12, 4'h1);
      check("ir 5", IR_5, 1);
      SR1MUX = 2'b01; SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
      tick();
      clear_ctl();
      check("add r2", dut.regs[2], 16'h8000);
      check("add nzp", {dut.n_flag, dut.z_flag, dut.p_flag}, 3'b100);
      load_ir(16'h0800);
      LD_BEN = 1;
      tick();
      clear_ctl();
      check("ben n", BEN, 1);

      for (int i = 0; i < 15; i++) begin
         load_ir(vecs[i].ir);
         SR1MUX = vecs[i].sr1mux; SR2MUX = vecs[i].sr2mux; ALUK = vecs[i].aluk;
         ADDR1MUX = vecs[i].addr1mux; ADDR2MUX = vecs[i].addr2mux; MARMUX = vecs[i].marmux;
         GateALU = (vecs[i].src == 2'd0);
         GateMARMUX = (vecs[i].src == 2'd1);
         GatePC = (vecs[i].src == 2'd2);
         #1;
         check($sformatf("vec%0d bus", i), dut.bus, vecs[i].exp_bus);
         check($sformatf("vec%0d conflict", i), Bus_Conflict, 0);
         clear_ctl();
      end

      // Zero and positive condition codes, BEN on other flags
      load_ir(16'h1442);
      SR1MUX = 2'b01; ALUK = 2'b01; GateALU = 1; LD_CC = 1;
      tick();
      check("cc zero", {dut.n_flag, dut.z_flag, dut.p_flag}, 3'b010);
      ALUK = 2'b11;
      tick();
      clear_ctl();
      check("cc pos", {dut.n_flag, dut.z_flag, dut.p_flag}, 3'b001);
      load_ir(16'h0800);
      LD_BEN = 1;
      tick();
      clear_ctl();
      check("ben n miss", BEN, 0);
      load_ir(16'h0200);
      LD_BEN = 1;
      tick();
      clear_ctl();
      check("ben p", BEN, 1);

      // Bus contention
      #1;
      check("no gate bus", dut.bus, 0);
      check("no gate conflict", Bus_Conflict, 0);
      GateALU = 1; GatePC = 1; LD_MAR = 1;
      #1;
      check("conflict flag", Bus_Conflict, 1);
      check("conflict bus", dut.bus, 0);
      tick();
      clear_ctl();
      check("conflict mar", dut.mar, 0);
      GatePC = 1; GateMDR = 1; GateALU = 1; GateMARMUX = 1;
      #1;
      check("all gates conflict", Bus_Conflict, 1);
      clear_ctl();

      // PC-relative offset in the wide build
      load_ir(16'h0100);
      ADDR1MUX = 0; ADDR2MUX = 2'b10;
      #1;
      check("w32 addr", dut32.addr_sum, 32'h0000_2F50);
      check("w16 addr", dut.addr_sum, 16'h2F50);
      clear_ctl();

      PCMUX = 2'b00; LD_PC = 1;
      tick();
      check("pc inc", dut.pc, 16'h3051);
      PCMUX = 2'b11;
      tick();
      check("pc hold", dut.pc, 16'h3051);
      PCMUX = 2'b10; ADDR2MUX = 2'b10;
      tick();
      clear_ctl();
      check("pc addr", dut.pc, 16'h2F51);

      // Busy-time loads, then Ready on the timeout edge
      GatePC = 1; LD_MAR = 1;
      tick();
      clear_ctl();
      MEM_Start = 1;
      tick();
      MEM_Start = 0;
      check("busy addr", Mem_Addr, 16'h2F51);
      LD_MAR = 1; LD_MDR = 1; MEM_Start = 1; GateMARMUX = 1; MARMUX = 0;
      tick();
      clear_ctl();
      check("busy mar", dut.mar, 16'h0000);
      check("busy mdr kept", dut.mdr, 16'h0100);
      check("busy addr kept", Mem_Addr, 16'h2F51);
      repeat (13) tick();
      check("busy at limit", Mem_CE, 1);
      Mem_Ready = 1; Mem_Rdata = 16'h5A5A;
      tick();
      Mem_Ready = 0;
      check("race ce", Mem_CE, 0);
      check("race r", R, 1);
      check("race err", Mem_Err, 0);
      check("race mdr", dut.mdr, 16'h5A5A);
      tick();
      check("race r single", R, 0);

      // Reset on the second busy cycle of a write
      GatePC = 1; LD_MAR = 1;
      tick();
      clear_ctl();
      MEM_Start = 1; MEM_Write = 1;
      tick();
      MEM_Start = 0; MEM_Write = 0;
      check("pre rst we", Mem_WE, 1);
      check("pre rst wdata", Mem_Wdata, 16'h5A5A);
      tick();
      Reset = 1; LD_PC = 1; LD_MAR = 1; MEM_Start = 1; GatePC = 1;
      tick();
      Reset = 0;
      clear_ctl();
      check("abort ce", Mem_CE, 0);
      check("abort r", R, 0);
      check("abort we", Mem_WE, 0);
      check("abort err", Mem_Err, 0);
      check("abort addr", Mem_Addr, 0);
      check("abort wdata", Mem_Wdata, 0);
      check("abort ben", BEN, 0);
      check("abort pc", dut.pc, 0);
      check("abort r1", dut.regs[1], 0);
      tick();
      check("abort r after", R, 0);
      check("abort ce after", Mem_CE, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/datapath_ext.md
DATAPATH_EXT -- requirements
Module: datapath_ext

Interface
REQ-001 Parameter WIDTH, default 16, datapath/bus/register width; SHALL be >= 16.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum busy cycles before a memory access aborts; range 1..255.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Mem_Rdata  in  WIDTH  read data from RAM.
REQ-006 Mem_Ready  in  1  RAM completion strobe.
REQ-007 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  in  1 each  register load enables.
REQ-008 GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers, one-hot.
REQ-009 ADDR1MUX, SR2MUX, MARMUX  in  1; ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK  in  2  mux/ALU selects, LC-3 encodings.
REQ-010 MEM_Start  in  1  begin memory access using MAR/MDR; MEM_Write  in  1  access is a write.
REQ-011 Mem_Addr, Mem_Wdata  out  WIDTH  registered RAM address/write data.
REQ-012 Mem_CE, Mem_WE  out  1  RAM chip enable / write enable.
REQ-013 R  out  1  one-cycle access-complete pulse; Mem_Err  out  1  last access timed out.
REQ-014 BEN, IR_5  out  1; IR_15_12  out  4; Bus_Conflict  out  1  more than one gate asserted.

Function
REQ-015 Bus SHALL carry the single gated source; all-zero when no gate or >1 gate asserted; Bus_Conflict = (popcount of gates > 1), combinational.
REQ-016 IR fields SHALL sit at LC-3 bit positions [15:0]; all offsets/immediates sign-extended to WIDTH; trapvect IR[7:0] zero-extended to WIDTH.
REQ-017 ALUK: 00 ADD, 01 AND, 10 NOT A, 11 pass A; ADD wraps modulo 2^WIDTH.
REQ-018 CC on LD_CC: N=Bus[WIDTH-1], Z=(Bus==0), P=~N&~Z; exactly one set after first load.
REQ-019 BEN on LD_BEN = IR[11]&N | IR[10]&Z | IR[9]&P.
REQ-020 Register file 8 x WIDTH, two async read ports, one write (LD_REG, DRMUX: 00 IR[11:9], 01 R7, 10 R6); DRMUX/SR1MUX=11 SHALL select R0.
REQ-021 PCMUX 00 PC+1, 01 Bus, 10 ADDR; 11 SHALL hold PC.
REQ-022 Memory FSM states IDLE, BUSY; Mem_CE=1 iff BUSY.
REQ-023 IDLE & MEM_Start at edge: -> BUSY; Mem_Addr<=MAR, Mem_Wdata<=MDR, Mem_WE<=MEM_Write, busy counter<=0, Mem_Err<=0.
REQ-024 BUSY & Mem_Ready at edge: -> IDLE; R=1 next cycle only; if read, MDR<=Mem_Rdata same edge.
REQ-025 BUSY, no Ready, counter==MEM_TIMEOUT-1: -> IDLE, R=1, Mem_Err<=1 (sticky until next MEM_Start), MDR unchanged.
REQ-026 Ready and timeout on same edge: Ready wins, Mem_Err stays 0.
REQ-027 MEM_Start while BUSY ignored; LD_MDR while BUSY ignored; LD_MAR while BUSY updates MAR but not Mem_Addr.
REQ-028 Mem_WE SHALL be 0 whenever IDLE.
REQ-029 Minimum access latency: MEM_Start edge n, Ready sampled edge n+1, R high cycle after edge n+1.

Reset
REQ-030 Reset at edge: MAR, MDR, IR, PC, BEN, N, Z, P, all 8 registers, Mem_Addr, Mem_Wdata, counter = 0; FSM -> IDLE; Mem_CE, Mem_WE, R, Mem_Err = 0.
REQ-031 Reset during BUSY SHALL abort access without R pulse; Reset overrides all loads and MEM_Start.

Verification
REQ-032 MAR=0x3000, MEM_Start, read, Ready after 3 BUSY cycles, Rdata=0x1234 -> Mem_CE high 3 cycles, R one pulse, MDR=0x1234, Mem_Err=0.
REQ-033 MDR=0xBEEF, MEM_Write, no Ready for 15 cycles -> R pulse after 15th BUSY cycle, Mem_Err=1, MDR=0xBEEF, Mem_WE low after.
REQ-034 R1=0x7FFF, ADD imm 1 into R2 with LD_CC -> R2=0x8000, N=1,Z=0,P=0; IR=0x0800 then LD_BEN -> BEN=1.
REQ-035 GateALU and GatePC together -> Bus=0, Bus_Conflict=1; LD_MAR loads 0.
REQ-036 Reset asserted on 2nd BUSY cycle -> next cycle Mem_CE=0, no R pulse, all outputs 0.
REQ-037 WIDTH=32 build: IR[8:0]=0x100 PC-relative -> ADDR=PC+0xFFFFFF00.
